// File: rtl/jtpopeye_ioctl_tx.sv
// ROM download transmitter: turns a valid/ready byte stream into the
// downloading/ioctl_addr/ioctl_data/ioctl_wr write stream used by the PROM/SDRAM loaders.
module jtpopeye_ioctl_tx #(
    parameter int TOTAL = 22'h12000,
    parameter int GAP   = 4,
    parameter int LEAD  = 2
) (
    input  logic        clk_rom,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  src_data,
    input  logic        src_valid,
    output logic        src_ready,
    output logic        downloading,
    output logic [21:0] ioctl_addr,
    output logic [7:0]  ioctl_data,
    output logic        ioctl_wr,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_FETCH,
        S_STROBE,
        S_GAP
    } state_t;

    localparam int LW = (LEAD > 1) ? $clog2(LEAD) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [LW-1:0] LEAD_LAST = LW'(LEAD - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [21:0]   ADDR_LAST = 22'(TOTAL - 1);

    state_t        state_reg, state_next;
    logic [LW-1:0] lead_cnt_reg, lead_cnt_next;
    logic [GW-1:0] gap_cnt_reg, gap_cnt_next;
    logic [21:0]   addr_reg, addr_next;
    logic [7:0]    data_reg, data_next;
    logic          dl_reg, dl_next;
    logic          done_reg, done_next;
    logic          first_reg, first_next;
    logic          accept;

    // An abort in FETCH withdraws ready so the source never loses a byte.
    assign src_ready   = (state_reg == S_FETCH) && !abort;
    assign accept      = src_ready && src_valid;
    assign ioctl_wr    = (state_reg == S_STROBE);
    assign downloading = dl_reg;
    assign ioctl_addr  = addr_reg;
    assign ioctl_data  = data_reg;
    assign done        = done_reg;

    always_comb begin
        state_next    = state_reg;
        lead_cnt_next = lead_cnt_reg;
        gap_cnt_next  = gap_cnt_reg;
        addr_next     = addr_reg;
        data_next     = data_reg;
        dl_next       = dl_reg;
        first_next    = first_reg;
        done_next     = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (start && !abort) begin
                    state_next    = S_LEAD;
                    dl_next       = 1'b1;
                    addr_next     = '0;
                    lead_cnt_next = '0;
                    first_next    = 1'b1;
                end
            end
            S_LEAD: begin
                if (lead_cnt_reg == LEAD_LAST) begin
                    state_next = S_FETCH;
                end else begin
                    lead_cnt_next = lead_cnt_reg + LW'(1);
                end
            end
            S_FETCH: begin
                // Address advances on acceptance, keeping it stable through the idle wait.
                if (accept) begin
                    data_next  = src_data;
                    first_next = 1'b0;
                    state_next = S_STROBE;
                    if (!first_reg) begin
                        addr_next = addr_reg + 22'd1;
                    end
                end
            end
            S_STROBE: begin
                if (GAP > 0) begin
                    state_next   = S_GAP;
                    gap_cnt_next = '0;
                end else if (addr_reg == ADDR_LAST) begin
                    state_next = S_IDLE;
                    dl_next    = 1'b0;
                    done_next  = 1'b1;
                end else begin
                    state_next = S_FETCH;
                end
            end
            S_GAP: begin
                if (gap_cnt_reg == GAP_LAST) begin
                    if (addr_reg == ADDR_LAST) begin
                        state_next = S_IDLE;
                        dl_next    = 1'b0;
                        done_next  = 1'b1;
                    end else begin
                        state_next = S_FETCH;
                    end
                end else begin
                    gap_cnt_next = gap_cnt_reg + GW'(1);
                end
            end
            default: begin
                state_next = S_IDLE;
                dl_next    = 1'b0;
            end
        endcase

        if (abort && (state_reg != S_IDLE)) begin
            state_next = S_IDLE;
            dl_next    = 1'b0;
            done_next  = 1'b0;
        end
    end

    always_ff @(posedge clk_rom) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            lead_cnt_reg <= '0;
            gap_cnt_reg  <= '0;
            addr_reg     <= '0;
            data_reg     <= '0;
            dl_reg       <= 1'b0;
            done_reg     <= 1'b0;
            first_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            lead_cnt_reg <= lead_cnt_next;
            gap_cnt_reg  <= gap_cnt_next;
            addr_reg     <= addr_next;
            data_reg     <= data_next;
            dl_reg       <= dl_next;
            done_reg     <= done_next;
            first_reg    <= first_next;
        end
    end

endmodule
